// File: rtl/hcsr04_pkg.sv
// hcsr04_pkg: shared state encoding and default timing constants for the HC-SR04 echo generator
package hcsr04_pkg;

    localparam int ECHO_W           = 24;
    localparam int DIST_W           = 14;
    localparam int TRIG_MIN_CYC_DEF = 1000;
    localparam int BURST_CYC_DEF    = 20000;
    localparam int CYC_PER_MM_DEF   = 588;
    localparam int MAX_MM_DEF       = 4000;
    localparam int TIMEOUT_CYC_DEF  = 3800000;
    localparam int HOLDOFF_CYC_DEF  = 1000000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG_HI,
        S_BURST,
        S_ECHO,
        S_HOLDOFF
    } state_e;

endpackage

// File: rtl/hcsr04_echo_gen_trig_qual.sv
// trig_qual: synchronizes trig, detects edges and measures the high width against the minimum
module trig_qual import hcsr04_pkg::*; #(
    parameter int TRIG_MIN_CYC = TRIG_MIN_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trig_i,
    input  logic idle_i,
    input  logic meas_i,
    output logic start_o,
    output logic accept_o,
    output logic reject_o
);

    localparam int CW = $clog2(TRIG_MIN_CYC + 1);

    logic [1:0]    sync_q;
    logic          prev_q;
    logic          trig_s;
    logic          sat;
    logic [CW-1:0] cnt_q, cnt_d;

    assign trig_s   = sync_q[1];
    assign sat      = cnt_q >= CW'(TRIG_MIN_CYC);
    assign start_o  = idle_i & trig_s & ~prev_q;
    assign accept_o = meas_i & ~trig_s & sat;
    assign reject_o = meas_i & ~trig_s & ~sat;

    // Width counter: restart at 1 on a fresh rise, saturate at the minimum, clear on the fall
    always_comb begin
        cnt_d = start_o                  ? CW'(1)
              : (meas_i && trig_s && !sat) ? cnt_q + CW'(1)
              : (meas_i && !trig_s)      ? '0
              : cnt_q;
    end

    // Two-flop synchronizer, edge-detect history and width counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], trig_i};
            prev_q <= trig_s;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/hcsr04_echo_gen.sv
// hcsr04_echo_gen: HC-SR04 responder producing a distance-coded echo pulse after a qualified trig
module hcsr04_echo_gen import hcsr04_pkg::*; #(
    parameter int TRIG_MIN_CYC = TRIG_MIN_CYC_DEF,
    parameter int BURST_CYC    = BURST_CYC_DEF,
    parameter int CYC_PER_MM   = CYC_PER_MM_DEF,
    parameter int MAX_MM       = MAX_MM_DEF,
    parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
    parameter int HOLDOFF_CYC  = HOLDOFF_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig,
    input  logic [DIST_W-1:0] dist_mm,
    output logic              echo,
    output logic              busy,
    output logic              trig_err
);

    state_e              state_q, state_d;
    logic [DIST_W-1:0]   dist_q;
    logic [ECHO_W-1:0]   len_q, cnt_q, cnt_d;
    logic                start, accept, reject;
    logic                in_range;
    logic                first_burst;

    trig_qual #(.TRIG_MIN_CYC(TRIG_MIN_CYC)) u_qual (
        .clk      (clk),
        .rst_n    (rst_n),
        .trig_i   (trig),
        .idle_i   (state_q == S_IDLE),
        .meas_i   (state_q == S_TRIG_HI),
        .start_o  (start),
        .accept_o (accept),
        .reject_o (reject)
    );

    assign in_range    = (dist_q != '0) && (int'(dist_q) <= MAX_MM);
    assign first_burst = (state_q == S_BURST) && (cnt_q == ECHO_W'(BURST_CYC - 1));

    // Sequencer: one shared down-counter times BURST, ECHO and HOLDOFF in turn
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:    state_d = start ? S_TRIG_HI : S_IDLE;
            S_TRIG_HI: begin
                state_d = accept ? S_BURST : reject ? S_IDLE : S_TRIG_HI;
                cnt_d   = accept ? ECHO_W'(BURST_CYC - 1) : cnt_q;
            end
            S_BURST: begin
                state_d = (cnt_q == '0) ? S_ECHO : S_BURST;
                cnt_d   = (cnt_q == '0) ? len_q - ECHO_W'(1) : cnt_q - ECHO_W'(1);
            end
            S_ECHO: begin
                state_d = (cnt_q == '0) ? S_HOLDOFF : S_ECHO;
                cnt_d   = (cnt_q == '0) ? ECHO_W'(HOLDOFF_CYC - 1) : cnt_q - ECHO_W'(1);
            end
            S_HOLDOFF: begin
                state_d = (cnt_q == '0) ? S_IDLE : S_HOLDOFF;
                cnt_d   = (cnt_q == '0) ? '0 : cnt_q - ECHO_W'(1);
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // State, counter, distance latch and the single-stage echo length multiply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dist_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept)
                dist_q <= dist_mm;
            if (first_burst)
                len_q <= in_range ? ECHO_W'(dist_q) * ECHO_W'(CYC_PER_MM) : ECHO_W'(TIMEOUT_CYC);
        end
    end

    // Registered outputs trail the state by one cycle, so relative pulse timing is exact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo     <= 1'b0;
            busy     <= 1'b0;
            trig_err <= 1'b0;
        end else begin
            echo     <= state_q == S_ECHO;
            busy     <= state_q inside {S_BURST, S_ECHO, S_HOLDOFF};
            trig_err <= reject;
        end
    end

endmodule

// File: doc/hcsr04_echo_gen.md
# hcsr04_echo_gen

Synthesizable model of the HC-SR04 ultrasonic sensor: the responder side of the trig/echo ranging protocol. It qualifies the trig pulse, waits out the burst interval, then drives an echo pulse whose width encodes a programmed target distance. It sits in place of the physical sensor, with `trig` and `echo` looped to the ranging block, for in-system loopback and bench self-check of the distance/display chain at 100 MHz.

## Interface
Parameters:
- `TRIG_MIN_CYC`, 1000: minimum qualifying trig high width, in cycles (10 µs).
- `BURST_CYC`, 20000: delay from trig acceptance to echo rise (200 µs, the 8-cycle 40 kHz burst).
- `CYC_PER_MM`, 588: echo cycles per mm of range (round trip at 340 m/s).
- `MAX_MM`, 4000: largest in-range distance.
- `TIMEOUT_CYC`, 3800000: echo width for no-target or out-of-range (38 ms).
- `HOLDOFF_CYC`, 1000000: dead time after echo falls (10 ms).

Ports:
- `clk` in 1: 100 MHz system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `trig` in 1: trigger from the ranging block; asynchronous to `clk`.
- `dist_mm` in 14: target distance in mm; sampled at trig acceptance.
- `echo` out 1: echo pulse, registered.
- `busy` out 1: high from acceptance through end of holdoff.
- `trig_err` out 1: one-cycle strobe when a trig pulse is rejected.

## Operation
- `trig` passes through a 2-flop synchronizer to give `trig_s`. All decisions use `trig_s`.
- States: IDLE, TRIG_HI, BURST, ECHO, HOLDOFF. They live in a package enum.
- IDLE to TRIG_HI when `trig_s` rises. The width counter clears to 1.
- TRIG_HI: the counter increments while `trig_s` is high and saturates at `TRIG_MIN_CYC`.
  - On the `trig_s` fall with count ≥ `TRIG_MIN_CYC`: latch `dist_mm`, go to BURST, set `busy`.
  - On the fall with count < `TRIG_MIN_CYC`: pulse `trig_err` for one cycle and return to IDLE.
- BURST: count `BURST_CYC` cycles. In the first BURST cycle, register the echo length:
  - `dist*CYC_PER_MM` if 1 ≤ dist ≤ `MAX_MM`;
  - otherwise `TIMEOUT_CYC`.
  - The length is 24 bits unsigned. The constant multiply is a single registered stage.
- ECHO: `echo` is high for exactly the echo-length cycles, then the block goes to HOLDOFF.
- HOLDOFF: count `HOLDOFF_CYC` cycles, then go to IDLE and clear `busy`.
- Trig activity in BURST, ECHO or HOLDOFF is ignored. It is not counted, causes no `trig_err`, and no request is queued. A trig that is already high when HOLDOFF ends is not accepted; only a fresh rise in IDLE starts TRIG_HI.
- Changes to `dist_mm` after acceptance have no effect on the pulse in flight.

## Timing
- Reset values: `echo`=0, `busy`=0, `trig_err`=0, state IDLE, all counters 0, synchronizer flops 0.
- Assertion of `rst_n` low forces all outputs low asynchronously, including mid-echo. After release the block is in IDLE and requires a new trig rise.
- Acceptance cycle: the first `clk` edge at which `trig_s`=0 after a qualifying high. This is 2 edges after the first edge that samples the `trig` pin low.
- `busy` rises 1 cycle after acceptance.
- `echo` rises exactly `BURST_CYC` cycles after `busy` rises. It is high for exactly N cycles: 588·dist, or `TIMEOUT_CYC`.
- `busy` falls `HOLDOFF_CYC` cycles after `echo` falls.
- `trig_err` is asserted in the cycle after the short `trig_s` fall.
- A trig high width measured at exactly `TRIG_MIN_CYC` is accepted; `TRIG_MIN_CYC`−1 is rejected.
- Required parameter constraints: `BURST_CYC` ≥ 2, `HOLDOFF_CYC` ≥ 1, and `MAX_MM·CYC_PER_MM` < 2^24.

## Structure
- `hcsr04_pkg`: the state enum, the default cycle constants, and `ECHO_W`=24.
- Sub-module `trig_qual`: the synchronizer, rise/fall detect and saturating width counter. Its outputs are `accept` and `reject` strobes. The top module holds the FSM, the length register and the BURST/ECHO/HOLDOFF counter, which is a single 24-bit down-counter reused across states.

## Test plan
- trig high 1200 cycles, `dist_mm`=100: `echo` rises 20001 cycles after acceptance and is high for exactly 58800 cycles. `busy` falls 1000000 cycles after `echo` falls.
- trig high 999 cycles: one-cycle `trig_err`, `echo` stays 0, `busy` stays 0. Then trig high 1000 cycles: accepted, normal echo.
- `dist_mm`=0, then `dist_mm`=4001, each with a valid trig: `echo` high 3800000 cycles both times. `dist_mm`=4000: 2352000 cycles.
- Valid trig with `dist_mm`=50. Drive `dist_mm`=3000 and a second 1200-cycle trig during ECHO: echo width stays 29400, there is no second echo, and `trig_err` stays 0.
- `rst_n` low for 3 cycles 10000 cycles into ECHO: `echo` and `busy` are 0 with no clock edge needed. After release, no echo occurs until a new valid trig.
- Sweep `dist_mm` over {1, 17, 1234, 3999} with reduced parameters (`BURST_CYC`=4, `HOLDOFF_CYC`=8): every echo width equals 588·dist exactly.
